// File: rtl/joypad_serializer_if.sv
// Joypad bus between the NES core side (master) and the controller model (slave).
interface joypad_serializer_if #(
  parameter int NUM_PORTS = 2,
  parameter int BITS      = 8,
  parameter int CW        = $clog2(BITS + 1)
);
  logic                      joypad_strobe;
  logic [NUM_PORTS-1:0]      joypad_clock;
  logic [NUM_PORTS*BITS-1:0] buttons;
  logic [NUM_PORTS*BITS-1:0] turbo_mask;
  logic                      frame_tick;
  logic [NUM_PORTS-1:0]      joypad_data;
  logic [NUM_PORTS*CW-1:0]   bit_count;
  logic [NUM_PORTS-1:0]      exhausted;
  logic                      turbo_phase;

  modport master (
    output joypad_strobe, joypad_clock, buttons, turbo_mask, frame_tick,
    input  joypad_data, bit_count, exhausted, turbo_phase
  );

  modport slave (
    input  joypad_strobe, joypad_clock, buttons, turbo_mask, frame_tick,
    output joypad_data, bit_count, exhausted, turbo_phase
  );
endinterface

// File: rtl/joypad_serializer.sv
// Parallel-load / serial-shift controller ports with turbo auto-fire.
// Each port latches its (turbo-gated) buttons while strobe is high and
// shifts one bit per falling edge of its own read clock afterwards.
module joypad_serializer #(
  parameter int NUM_PORTS = 2,
  parameter int BITS      = 8,
  parameter int FILL_BIT  = 1,
  parameter int TURBO_DIV = 2,
  parameter int CW        = $clog2(BITS + 1)
) (
  input logic                clk,
  input logic                reset,
  joypad_serializer_if.slave jp
);

  localparam int DW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [BITS-1:0]      shift_q [NUM_PORTS];
  logic [BITS-1:0]      shift_d [NUM_PORTS];
  logic [CW-1:0]        cnt_q   [NUM_PORTS];
  logic [CW-1:0]        cnt_d   [NUM_PORTS];
  logic [BITS-1:0]      eff_s   [NUM_PORTS];
  logic [NUM_PORTS-1:0] last_clk_q;
  logic [NUM_PORTS-1:0] fall_s;
  logic [DW-1:0]        div_q, div_d;
  logic                 phase_q, phase_d;

  // Next-state for every port: load beats shift, count saturates at BITS.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff_s[i]  = jp.buttons[i*BITS +: BITS]
                & ~(jp.turbo_mask[i*BITS +: BITS] & {BITS{~phase_q}});
      fall_s[i] = last_clk_q[i] & ~jp.joypad_clock[i];
      shift_d[i] = shift_q[i];
      cnt_d[i]   = cnt_q[i];
      if (jp.joypad_strobe) begin
        shift_d[i] = eff_s[i];
        cnt_d[i]   = '0;
      end else if (fall_s[i]) begin
        shift_d[i] = {1'(FILL_BIT), shift_q[i][BITS-1:1]};
        if (cnt_q[i] == CW'(BITS)) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        shift_d[i] = shift_q[i];
        cnt_d[i]   = cnt_q[i];
      end
    end
  end

  // Turbo divider: phase toggles every TURBO_DIV frame ticks.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (jp.frame_tick) begin
      if (div_q == DW'(TURBO_DIV - 1)) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d   = div_q + DW'(1);
        phase_d = phase_q;
      end
    end else begin
      div_d   = div_q;
      phase_d = phase_q;
    end
  end

  // State registers; reset clears last_clk so a clock held high makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shift_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      last_clk_q <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shift_q[i] <= shift_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      last_clk_q <= jp.joypad_clock;
      div_q      <= div_d;
      phase_q    <= phase_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign jp.joypad_data[g]           = shift_q[g][0];
    assign jp.bit_count[g*CW +: CW]    = cnt_q[g];
    assign jp.exhausted[g]             = (cnt_q[g] == CW'(BITS));
  end
  assign jp.turbo_phase = phase_q;

endmodule

// File: tb/tb_joypad_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// reference model that tracks, per port, the latched button snapshot and
// how many bits have been consumed from it.
module tb_joypad_serializer;
  localparam int NP = 2;
  localparam int B  = 8;
  localparam int FB = 1;
  localparam int TD = 2;
  localparam int CW = $clog2(B + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  joypad_serializer_if #(.NUM_PORTS(NP), .BITS(B), .CW(CW)) jp ();

  joypad_serializer #(.NUM_PORTS(NP), .BITS(B), .FILL_BIT(FB),
                      .TURBO_DIV(TD), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .jp    (jp.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  logic [B-1:0] m_snap [NP];
  int           m_used [NP];
  logic [NP-1:0] m_last;
  int           m_ticks;

  task automatic check_eq(input string tag, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_phase();
    return (m_ticks / TD) % 2;
  endfunction

  function automatic int m_data(input int p);
    if (m_used[p] < B) return int'(m_snap[p][m_used[p]]);
    return FB;
  endfunction

  // advance the model by one clock using the inputs currently driven
  task automatic model_update();
    logic [B-1:0] btn, msk, eff;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin m_snap[p] = '0; m_used[p] = 0; end
      m_last = '0;
      m_ticks = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        btn = jp.buttons[p*B +: B];
        msk = jp.turbo_mask[p*B +: B];
        eff = (m_phase() == 1) ? btn : (btn & ~msk);
        if (jp.joypad_strobe) begin
          m_snap[p] = eff;
          m_used[p] = 0;
        end else if (m_last[p] && !jp.joypad_clock[p]) begin
          if (m_used[p] < B) m_used[p]++;
        end
      end
      m_last = jp.joypad_clock;
      if (jp.frame_tick) m_ticks++;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("data%0d", p), int'(jp.joypad_data[p]), m_data(p));
      check_eq($sformatf("count%0d", p), int'(jp.bit_count[p*CW +: CW]), m_used[p]);
      check_eq($sformatf("exh%0d", p), int'(jp.exhausted[p]), (m_used[p] == B) ? 1 : 0);
    end
    check_eq("phase", int'(jp.turbo_phase), m_phase());
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_update();
      #1;
      check_all();
    end
  endtask

  task automatic fall_edge(input int p);
    jp.joypad_clock[p] = 1'b1; step();
    jp.joypad_clock[p] = 1'b0; step();
  endtask

  task automatic load();
    jp.joypad_strobe = 1'b1; step();
    jp.joypad_strobe = 1'b0; step();
  endtask

  task automatic tick();
    jp.frame_tick = 1'b1; step();
    jp.frame_tick = 1'b0; step();
  endtask

  logic [7:0] pat;

  initial begin
    reset = 1'b1;
    jp.joypad_strobe = 1'b0;
    jp.joypad_clock  = '0;
    jp.buttons       = '0;
    jp.turbo_mask    = '0;
    jp.frame_tick    = 1'b0;
    step(2);
    check_eq("rst_data", int'(jp.joypad_data), 0);
    check_eq("rst_count", int'(jp.bit_count), 0);
    reset = 1'b0;
    step();

    // 0xA5 read out LSB first, then fill bits
    pat = 8'b1010_0101;
    jp.buttons[7:0] = pat;
    load();
    check_eq("a5_bit0", int'(jp.joypad_data[0]), int'(pat[0]));
    for (int j = 1; j <= 8; j++) begin
      fall_edge(0);
      check_eq("a5_cnt", int'(jp.bit_count[CW-1:0]), j);
      if (j < 8) check_eq("a5_bit", int'(jp.joypad_data[0]), int'(pat[j]));
    end
    check_eq("a5_exh", int'(jp.exhausted[0]), 1);
    for (int j = 0; j < 3; j++) begin
      fall_edge(0);
      check_eq("fill_data", int'(jp.joypad_data[0]), 1);
      check_eq("fill_cnt", int'(jp.bit_count[CW-1:0]), 8);
    end
    check_eq("p1_idle", int'(jp.bit_count[2*CW-1:CW]), 0);

    // strobe held high tracks live buttons, clock ignored
    jp.buttons[7:0] = 8'h01;
    jp.joypad_strobe = 1'b1; step();
    check_eq("strobe_live1", int'(jp.joypad_data[0]), 1);
    jp.buttons[7:0] = 8'h00;
    jp.joypad_clock[0] = 1'b1; step();
    jp.joypad_clock[0] = 1'b0; step();
    check_eq("strobe_live0", int'(jp.joypad_data[0]), 0);
    check_eq("strobe_nocnt", int'(jp.bit_count[CW-1:0]), 0);
    jp.joypad_strobe = 1'b0; step();

    // strobe and port1 fall in the same cycle: load wins
    jp.buttons[15:8] = 8'h02;
    jp.joypad_clock[1] = 1'b1; step();
    jp.joypad_clock[1] = 1'b0; jp.joypad_strobe = 1'b1; step();
    check_eq("ld_wins_data", int'(jp.joypad_data[1]), 0);
    check_eq("ld_wins_cnt", int'(jp.bit_count[2*CW-1:CW]), 0);
    jp.joypad_strobe = 1'b0; step();

    // turbo on port0 bit0
    jp.turbo_mask[7:0] = 8'h01;
    jp.buttons[7:0] = 8'h01;
    load();
    check_eq("turbo_ph0", int'(jp.joypad_data[0]), 0);
    tick(); tick();
    check_eq("turbo_phase1", int'(jp.turbo_phase), 1);
    check_eq("turbo_keep", int'(jp.joypad_data[0]), 0);
    load();
    check_eq("turbo_ph1", int'(jp.joypad_data[0]), 1);
    tick(); tick();
    check_eq("turbo_phase0", int'(jp.turbo_phase), 0);
    jp.turbo_mask = '0;

    // reset mid-read with clock held high
    jp.buttons[7:0] = 8'hFF;
    load();
    fall_edge(0); fall_edge(0); fall_edge(0);
    jp.joypad_clock[0] = 1'b1; step();
    reset = 1'b1; step();
    reset = 1'b0; step();
    check_eq("rst_mid_data", int'(jp.joypad_data), 0);
    check_eq("rst_mid_cnt", int'(jp.bit_count), 0);
    check_eq("rst_mid_exh", int'(jp.exhausted), 0);
    jp.joypad_clock[0] = 1'b0; step();
    check_eq("post_rst_cnt", int'(jp.bit_count[CW-1:0]), 1);
    check_eq("post_rst_data", int'(jp.joypad_data[0]), 0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 299) == 0);
      jp.joypad_strobe = ($urandom_range(0, 19) == 0);
      jp.joypad_clock  = NP'($urandom);
      jp.frame_tick    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) jp.buttons = (NP*B)'($urandom);
      if ($urandom_range(0, 15) == 0) jp.turbo_mask = (NP*B)'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
